// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - SECDED Hamming encoder/decoder with a registered valid/ready output stage
//
// Purpose:
//   Encodes a DATA_W payload into a CODE_W extended-Hamming codeword (mode=0)
//   or checks/corrects a CODE_W codeword (mode=1). The result is captured in a
//   single output register, giving one cycle of latency and full throughput.
//   Code layout: index 0 holds overall even parity; index i>=1 is Hamming
//   position i, with parity at power-of-two positions and data bits d0.. at
//   the remaining positions in ascending order.
//
// Optional feature:
//   HAMMING_ERR_CNT_EN - when defined, saturating 16-bit counters of corrected
//   (sec_cnt) and uncorrectable (ded_cnt) results are built. When undefined,
//   both counters read 0 and cnt_clr is ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   mode       in   0 = encode, 1 = decode (sampled with in_valid)
//   in_valid   in   input word valid
//   in_ready   out  block can accept input
//   data_in    in   DATA_W payload (encode only)
//   code_in    in   CODE_W codeword (decode only)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   code_out   out  encoded / corrected codeword
//   data_out   out  echoed / corrected payload
//   syndrome   out  decode syndrome (0 when encoding)
//   err_single out  single-bit error corrected
//   err_double out  uncorrectable error detected
//   cnt_clr    in   synchronous clear of both counters
//   sec_cnt    out  corrected-error count
//   ded_cnt    out  uncorrectable-error count

module hamming_secded_codec #(
  parameter int DATA_W = 8,
  // Smallest r with 2^r >= DATA_W + r + 1, evaluated over the legal range.
  localparam int P_W = ((DATA_W + 4) <= 8)  ? 3 :
                       ((DATA_W + 5) <= 16) ? 4 :
                       ((DATA_W + 6) <= 32) ? 5 :
                       ((DATA_W + 7) <= 64) ? 6 : 7,
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code_out,
  output logic [DATA_W-1:0] data_out,
  output logic [P_W-1:0]    syndrome,
  output logic              err_single,
  output logic              err_double,
  input  logic              cnt_clr,
  output logic [15:0]       sec_cnt,
  output logic [15:0]       ded_cnt
);

  // XOR of the indices of all set bits at Hamming positions 1..CODE_W-1.
  function automatic logic [P_W-1:0] index_xor(input logic [CODE_W-1:0] c);
    logic [P_W-1:0] s;
    s = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (c[i]) s = s ^ P_W'(i);
    end
    return s;
  endfunction

  // Pull the data bits out of the non-power-of-two positions.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic [P_W-1:0]    s;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    // With parity slots still zero, bit k of the index XOR is exactly the
    // parity over data positions that have bit k set.
    s = index_xor(c);
    for (int k = 0; k < P_W; k++) begin
      c[1 << k] = s[k];
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  logic [CODE_W-1:0] enc_code;
  logic [P_W-1:0]    dec_syn;
  logic              dec_overall;
  logic              dec_single;
  logic              dec_double;
  logic [CODE_W-1:0] dec_code;
  logic [DATA_W-1:0] dec_data;

  logic [CODE_W-1:0] nxt_code;
  logic [DATA_W-1:0] nxt_data;
  logic [P_W-1:0]    nxt_syn;
  logic              nxt_single;
  logic              nxt_double;

  assign enc_code = encode(data_in);

  always_comb begin
    dec_syn     = index_xor(code_in);
    dec_overall = ^code_in;
    dec_single  = 1'b0;
    dec_double  = 1'b0;
    dec_code    = code_in;
    if (dec_overall) begin
      // Odd overall parity: a single flip, unless the syndrome points past
      // the end of the codeword (only possible with multiple flips).
      if (int'(dec_syn) <= CODE_W - 1) begin
        dec_single = 1'b1;
        dec_code   = code_in ^ (CODE_W'(1) << dec_syn);
      end else begin
        dec_double = 1'b1;
      end
    end else if (dec_syn != '0) begin
      dec_double = 1'b1;
    end
    dec_data = extract_data(dec_code);
  end

  always_comb begin
    nxt_code   = enc_code;
    nxt_data   = data_in;
    nxt_syn    = '0;
    nxt_single = 1'b0;
    nxt_double = 1'b0;
    if (mode) begin
      nxt_code   = dec_code;
      nxt_data   = dec_data;
      nxt_syn    = dec_syn;
      nxt_single = dec_single;
      nxt_double = dec_double;
    end
  end

  // Output stage may load whenever it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      code_out   <= '0;
      data_out   <= '0;
      syndrome   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        code_out   <= nxt_code;
        data_out   <= nxt_data;
        syndrome   <= nxt_syn;
        err_single <= nxt_single;
        err_double <= nxt_double;
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (out_xfer && err_single && (sec_cnt != 16'hFFFF)) sec_cnt <= sec_cnt + 16'd1;
      if (out_xfer && err_double && (ded_cnt != 16'hFFFF)) ded_cnt <= ded_cnt + 16'd1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - scoreboard bench for hamming_secded_codec
module tb_hamming_secded_codec;

  localparam int DATA_W = 8;
  localparam int P_W    = 4;
  localparam int CODE_W = 13;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] data;
    logic [P_W-1:0]    syn;
    logic              es;
    logic              ed;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [CODE_W-1:0] code_in = '0;
  logic              in_ready;
  logic              out_valid;
  logic [CODE_W-1:0] code_out;
  logic [DATA_W-1:0] data_out;
  logic [P_W-1:0]    syndrome;
  logic              err_single;
  logic              err_double;
  logic [15:0]       sec_cnt;
  logic [15:0]       ded_cnt;

  hamming_secded_codec #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .code_out(code_out), .data_out(data_out), .syndrome(syndrome),
    .err_single(err_single), .err_double(err_double), .cnt_clr(cnt_clr),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_force = 1;   // -1 random, else forced value
  int   clr_force = 0;     // -1 random, else forced value
  int   model_sec = 0;
  int   model_ded = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [CODE_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic [P_W-1:0] s, input logic es, input logic ed);
    exp_t e;
    e.code = c; e.data = d; e.syn = s; e.es = es; e.ed = ed;
    return e;
  endfunction

  // Reference encoder: place data, then each parity bit makes the count of
  // ones over its covered positions even; bit 0 makes the whole word even.
  function automatic logic [CODE_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c, m;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++)
      if ($countones(i) != 1) begin
        c[i] = d[j];
        j++;
      end
    for (int k = 0; k < P_W; k++) begin
      m = '0;
      for (int i = 1; i < CODE_W; i++)
        if (((i >> k) & 1) == 1) m[i] = 1'b1;
      c[1 << k] = ($countones(c & m) % 2) == 1;
    end
    c[0] = ($countones(c) % 2) == 1;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] ref_extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++)
      if ($countones(i) != 1) begin
        d[j] = c[i];
        j++;
      end
    return d;
  endfunction

  // Random word: encode, or decode of a clean codeword with 0, 1 or 2 known flips.
  task automatic gen(output logic m, output logic [DATA_W-1:0] din,
                     output logic [CODE_W-1:0] cin, output exp_t e);
    logic [DATA_W-1:0] d;
    logic [CODE_W-1:0] good, one;
    int a, b, nf;
    one  = 1;
    d    = DATA_W'($urandom);
    din  = DATA_W'($urandom);
    cin  = CODE_W'($urandom);
    m    = 1'($urandom_range(0, 1));
    good = ref_encode(d);
    a    = $urandom_range(0, CODE_W - 1);
    b    = $urandom_range(0, CODE_W - 1);
    while (b == a) b = $urandom_range(0, CODE_W - 1);
    nf   = $urandom_range(0, 2);
    if (!m) begin
      din = d;
      e = mk(good, d, '0, 1'b0, 1'b0);
    end else if (nf == 0) begin
      cin = good;
      e = mk(good, d, '0, 1'b0, 1'b0);
    end else if (nf == 1) begin
      cin = good ^ (one << a);
      e = mk(good, d, P_W'(a), 1'b1, 1'b0);
    end else begin
      cin = good ^ (one << a) ^ (one << b);
      e = mk(cin, ref_extract(cin), P_W'(a ^ b), 1'b0, 1'b1);
    end
  endtask

  // Called just after a falling edge; returns after the falling edge that
  // follows acceptance.
  task automatic send(input logic m, input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] c,
                      input exp_t e, output int tries);
    logic acc;
    tries = 0;
    acc = 1'b0;
    mode = m; data_in = d; code_in = c; in_valid = 1'b1;
    while (!acc && tries < 50) begin
      #1;
      acc = in_ready;
      tries++;
      if (acc) sb.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = (ready_force < 0) ? ($urandom_range(0, 3) != 0) : ready_force[0];
      cnt_clr   = (clr_force < 0) ? ($urandom_range(0, 15) == 0) : clr_force[0];
    end
  end

  // Monitor: compares presented results against the scoreboard front, and
  // pops on each output transfer.
  initial begin
    exp_t e;
    logic held, xfer;
    int exp_sec, exp_ded;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || !mon_en) begin
        held = 1'b0;
        continue;
      end
`ifdef HAMMING_ERR_CNT_EN
      exp_sec = model_sec;
      exp_ded = model_ded;
`else
      exp_sec = 0;
      exp_ded = 0;
`endif
      chk("sec_cnt", 32'(sec_cnt), 32'(exp_sec));
      chk("ded_cnt", 32'(ded_cnt), 32'(exp_ded));
      if (held) chk("hold_valid", 32'(out_valid), 32'd1);
      held = 1'b0;
      xfer = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("code_out", 32'(code_out), 32'(e.code));
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("syndrome", 32'(syndrome), 32'(e.syn));
          chk("err_single", 32'(err_single), 32'(e.es));
          chk("err_double", 32'(err_double), 32'(e.ed));
          if (out_ready) begin
            void'(sb.pop_front());
            xfer = 1'b1;
          end else begin
            held = 1'b1;
          end
        end
      end
      if (cnt_clr) begin
        model_sec = 0;
        model_ded = 0;
      end else if (xfer) begin
        if (e.es && model_sec < 65535) model_sec++;
        if (e.ed && model_ded < 65535) model_ded++;
      end
    end
  end

  initial begin
    exp_t e;
    int tries;
    logic m;
    logic [DATA_W-1:0] d;
    logic [CODE_W-1:0] c;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_code_out", 32'(code_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_syndrome", 32'(syndrome), 32'd0);
    chk("rst_flags", 32'({err_single, err_double}), 32'd0);
    chk("rst_counters", 32'({sec_cnt, ded_cnt}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors for DATA_W=8.
    send(1'b0, 8'hA5, CODE_W'($urandom), mk(13'h144E, 8'hA5, 4'd0, 1'b0, 1'b0), tries);
    send(1'b1, DATA_W'($urandom), 13'h140E, mk(13'h144E, 8'hA5, 4'd6, 1'b1, 1'b0), tries);
    send(1'b1, DATA_W'($urandom), 13'h100E, mk(13'h100E, 8'h81, 4'd12, 1'b0, 1'b1), tries);
    send(1'b1, DATA_W'($urandom), 13'h144F, mk(13'h144E, 8'hA5, 4'd0, 1'b1, 1'b0), tries);
    repeat (2) @(negedge clk);

    // Backpressure: hold the output for three cycles with a word waiting.
    ready_force = 0;
    gen(m, d, c, e);
    send(m, d, c, e, tries);
    gen(m, d, c, e);
    mode = m; data_in = d; code_in = c; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    ready_force = 1;
    @(negedge clk);
    send(m, d, c, e, tries);
    chk("resume_first_try", 32'(tries), 32'd1);
    for (int k = 0; k < 6; k++) begin
      gen(m, d, c, e);
      send(m, d, c, e, tries);
      chk("stream_rate", 32'(tries), 32'd1);
    end

    // Randomized traffic with random backpressure and counter clears.
    ready_force = -1;
    clr_force = -1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      gen(m, d, c, e);
      send(m, d, c, e, tries);
    end

    // Reset while a result is held.
    @(posedge clk);
    ready_force = 0;
    clr_force = 0;
    @(negedge clk);
    gen(m, d, c, e);
    send(m, d, c, e, tries);
    #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_code_out", 32'(code_out), 32'd0);
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_syndrome", 32'(syndrome), 32'd0);
    chk("mid_rst_flags", 32'({err_single, err_double}), 32'd0);
    chk("mid_rst_counters", 32'({sec_cnt, ded_cnt}), 32'd0);
    sb.delete();
    model_sec = 0;
    model_ded = 0;
    ready_force = 1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Counter clear coincident with a corrected-error transfer.
    d = DATA_W'($urandom);
    c = ref_encode(d);
    send(1'b1, DATA_W'($urandom), c ^ 13'h0010, mk(c, d, 4'd4, 1'b1, 1'b0), tries);
    @(posedge clk);
    clr_force = 1;
    @(negedge clk);
    @(posedge clk);
    clr_force = 0;
    repeat (2) @(negedge clk);
    #1 chk("clr_priority", 32'(sec_cnt), 32'd0);

    // Drain.
    ready_force = 1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
